// File: rtl/hcode_stream_arbiter.sv
// hcode_stream_arbiter: round-robin, burst-capped merge of NUM_CH ap_fifo producers onto one ap_fifo writer.
// Define HCODE_ARB_STATS_EN to add per-channel popped-word counters readable via stat_sel/stat_words.
module hcode_stream_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 128,
  parameter int BURST_MAX = 16
) (
  input  logic                     ip_clk,
  input  logic                     ip_rst_n,
  input  logic [NUM_CH*DATA_W-1:0] ch_din,
  input  logic [NUM_CH-1:0]        ch_write,
  output logic [NUM_CH-1:0]        ch_full,
  output logic [DATA_W-1:0]        out_r_din,
  output logic                     out_r_write,
  input  logic                     out_r_full,
  output logic [NUM_CH-1:0]        grant,
  output logic                     busy
`ifdef HCODE_ARB_STATS_EN
  ,
  input  logic [$clog2(NUM_CH)-1:0] stat_sel,
  output logic [31:0]               stat_words
`endif
);
  localparam int PW = $clog2(NUM_CH);
  localparam int BW = $clog2(BURST_MAX + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   hold_v_q, hold_v_d, grant_q, grant_d, pop, load;
  logic [DATA_W-1:0]   hold_q [NUM_CH];
  logic [DATA_W-1:0]   hold_d [NUM_CH];
  logic [BW-1:0]       beat_cnt_q, beat_cnt_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d, g, nxt_ptr;
  logic                rel;
  // First set bit of v searching upward from p; the wrap is an explicit compare so odd NUM_CH works.
  function automatic logic [PW-1:0] pick(input logic [NUM_CH-1:0] v, input logic [PW-1:0] p);
    logic [PW-1:0] r;
    int j;
    r = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (v[j]) r = PW'(j);
    end
    return r;
  endfunction
  function automatic logic [NUM_CH-1:0] oh(input logic [PW-1:0] i);
    return NUM_CH'(1) << i;
  endfunction
  always_comb begin
    g = '0;
    for (int i = 0; i < NUM_CH; i++) if (grant_q[i]) g = PW'(i);
    pop      = {NUM_CH{state_q == GRANT && !out_r_full}} & grant_q & hold_v_q;
    ch_full  = hold_v_q & ~pop;
    load     = ch_write & ~ch_full;
    hold_v_d = load | (hold_v_q & ~pop);
    for (int i = 0; i < NUM_CH; i++) hold_d[i] = load[i] ? ch_din[i*DATA_W +: DATA_W] : hold_q[i];
    out_r_write = |pop;
    out_r_din   = out_r_write ? hold_q[g] : '0;
    grant       = grant_q;
    busy        = |hold_v_q || state_q == GRANT;
  end
  // Release when the granted producer ran dry or the burst cap was just reached; regrant with no bubble.
  always_comb begin
    nxt_ptr    = (g == PW'(NUM_CH - 1)) ? '0 : g + 1'b1;
    rel        = !hold_v_d[g] || (pop[g] && beat_cnt_q == BW'(BURST_MAX - 1));
    state_d    = state_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    if (state_q == IDLE) begin
      state_d    = |hold_v_q ? GRANT : IDLE;
      grant_d    = |hold_v_q ? oh(pick(hold_v_q, rr_ptr_q)) : '0;
      beat_cnt_d = '0;
    end else if (rel) begin
      rr_ptr_d   = nxt_ptr;
      beat_cnt_d = '0;
      state_d    = |hold_v_d ? GRANT : IDLE;
      grant_d    = |hold_v_d ? oh(pick(hold_v_d, nxt_ptr)) : '0;
    end else begin
      beat_cnt_d = pop[g] ? beat_cnt_q + 1'b1 : beat_cnt_q;
    end
  end
  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      hold_v_q   <= '0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) hold_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      hold_v_q   <= hold_v_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      for (int i = 0; i < NUM_CH; i++) hold_q[i] <= hold_d[i];
    end
  end
`ifdef HCODE_ARB_STATS_EN
  logic [31:0] cnt_q [NUM_CH];
  logic [31:0] cnt_d [NUM_CH];
  logic [31:0] stat_words_q, stat_words_d;
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) cnt_d[i] = cnt_q[i] + 32'(pop[i]);
    stat_words_d = (int'(stat_sel) < NUM_CH) ? cnt_q[stat_sel] : '0;
    stat_words   = stat_words_q;
  end
  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      stat_words_q <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      stat_words_q <= stat_words_d;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`endif
endmodule
